// File: rtl/pr8_reg_alu_if.sv
// Bus between the lab processor control and the register-file/ALU execute stage.
// The master drives the instruction fields; the slave returns read data and flags.
interface pr8_reg_alu_if #(
   parameter int COMAND_WIDTH = 4,
   parameter int DATA_WIDTH   = 4,
   parameter int ADDR_WIDTH   = 4
);
   logic [COMAND_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0]   addr_a;
   logic [ADDR_WIDTH-1:0]   addr_b;
   logic                    wr_re;
   logic [DATA_WIDTH-1:0]   data_a;
   logic [DATA_WIDTH-1:0]   data_b;
   logic [DATA_WIDTH-1:0]   result;
   logic                    carry;
   logic                    zero;

   modport master (
      output instr, addr_a, addr_b, wr_re,
      input  data_a, data_b, result, carry, zero
   );

   modport slave (
      input  instr, addr_a, addr_b, wr_re,
      output data_a, data_b, result, carry, zero
   );
endinterface

// File: rtl/pr8_reg_alu.sv
// Register file with a 16-operation ALU; each edge in write mode executes one
// instruction on RF[addr_a]/RF[addr_b] and writes back to RF[addr_a].
module pr8_reg_alu #(
   parameter int COMAND_WIDTH = 4,
   parameter int DATA_WIDTH   = 4,
   parameter int ADDR_WIDTH   = 4
) (
   input logic          clk,
   input logic          clr,
   pr8_reg_alu_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int IMM_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

   typedef enum logic [3:0] {
      OP_LDI = 4'd0,  OP_MOV = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3,
      OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7,
      OP_INC = 4'd8,  OP_DEC = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11,
      OP_ROL = 4'd12, OP_ROR = 4'd13, OP_CLR = 4'd14, OP_NOP = 4'd15
   } op_e;

   logic [DATA_WIDTH-1:0] rf [DEPTH];
   op_e                   op;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic [IMM_W-1:0]      imm;
   logic [DATA_WIDTH-1:0] alu_r;
   logic [DATA_WIDTH:0]   wide;
   logic                  alu_c;
   logic                  alu_wr;

   assign op          = op_e'(bus.instr[3:0]);
   assign op_a        = rf[bus.addr_a];
   assign op_b        = rf[bus.addr_b];
   assign imm         = IMM_W'(bus.addr_b);
   assign bus.data_a  = op_a;
   assign bus.data_b  = op_b;

   // ALU: carry defaults to its held value so only arithmetic/shift ops touch it
   always_comb begin
      alu_r  = '0;
      alu_c  = bus.carry;
      alu_wr = 1'b1;
      wide   = '0;
      case (op)
         OP_LDI: alu_r = imm[DATA_WIDTH-1:0];
         OP_MOV: alu_r = op_b;
         OP_ADD: begin
            wide  = {1'b0, op_a} + {1'b0, op_b};
            alu_r = wide[DATA_WIDTH-1:0];
            alu_c = wide[DATA_WIDTH];
         end
         OP_SUB: begin
            wide  = {1'b0, op_a} - {1'b0, op_b};
            alu_r = wide[DATA_WIDTH-1:0];
            alu_c = wide[DATA_WIDTH];
         end
         OP_AND: alu_r = op_a & op_b;
         OP_OR:  alu_r = op_a | op_b;
         OP_XOR: alu_r = op_a ^ op_b;
         OP_NOT: alu_r = ~op_b;
         OP_INC: begin
            wide  = {1'b0, op_a} + {{DATA_WIDTH{1'b0}}, 1'b1};
            alu_r = wide[DATA_WIDTH-1:0];
            alu_c = wide[DATA_WIDTH];
         end
         OP_DEC: begin
            wide  = {1'b0, op_a} - {{DATA_WIDTH{1'b0}}, 1'b1};
            alu_r = wide[DATA_WIDTH-1:0];
            alu_c = wide[DATA_WIDTH];
         end
         OP_SHL: begin
            alu_r = {op_a[DATA_WIDTH-2:0], 1'b0};
            alu_c = op_a[DATA_WIDTH-1];
         end
         OP_SHR: begin
            alu_r = {1'b0, op_a[DATA_WIDTH-1:1]};
            alu_c = op_a[0];
         end
         OP_ROL: begin
            alu_r = {op_a[DATA_WIDTH-2:0], op_a[DATA_WIDTH-1]};
            alu_c = op_a[DATA_WIDTH-1];
         end
         OP_ROR: begin
            alu_r = {op_a[0], op_a[DATA_WIDTH-1:1]};
            alu_c = op_a[0];
         end
         OP_CLR: alu_r = '0;
         OP_NOP: alu_wr = 1'b0;
      endcase
   end

   // Read mode only mirrors RF[addr_a] into result; the RF itself stays frozen
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
         bus.result <= '0;
         bus.carry  <= 1'b0;
         bus.zero   <= 1'b0;
      end else if (bus.wr_re) begin
         bus.result <= op_a;
         bus.zero   <= (op_a == '0);
      end else if (alu_wr) begin
         rf[bus.addr_a] <= alu_r;
         bus.result     <= alu_r;
         bus.carry      <= alu_c;
         bus.zero       <= (alu_r == '0);
      end
   end
endmodule

// File: tb/tb_pr8_reg_alu.sv
// Directed bench for pr8_reg_alu: expected outputs are queued as each step is
// driven and popped for comparison after the clock edge.
module tb_pr8_reg_alu;
   logic clk;
   logic clr;
   int   vectors;
   int   miscompares;

   typedef struct {
      string      tag;
      logic [3:0] res;
      logic       c;
      logic       z;
      logic [3:0] da;
   } exp_t;

   exp_t       sb [$];
   logic [3:0] rf_model [16];

   pr8_reg_alu_if #(.COMAND_WIDTH(4), .DATA_WIDTH(4), .ADDR_WIDTH(4)) bus_if ();

   pr8_reg_alu #(.COMAND_WIDTH(4), .DATA_WIDTH(4), .ADDR_WIDTH(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic compareVal(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         compareVal({e.tag, ".result"}, bus_if.result, e.res);
         compareVal({e.tag, ".carry"},  {3'b0, bus_if.carry}, {3'b0, e.c});
         compareVal({e.tag, ".zero"},   {3'b0, bus_if.zero},  {3'b0, e.z});
         compareVal({e.tag, ".data_a"}, bus_if.data_a, e.da);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic wr,
                                input logic [3:0] res, input logic c, input logic z,
                                input logic [3:0] da);
      exp_t e;
      bus_if.instr  = op;
      bus_if.addr_a = a;
      bus_if.addr_b = b;
      bus_if.wr_re  = wr;
      e.tag = tag; e.res = res; e.c = c; e.z = z; e.da = da;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      clr           = 1'b0;
      bus_if.instr  = 4'd15;
      bus_if.addr_a = 4'd0;
      bus_if.addr_b = 4'd0;
      bus_if.wr_re  = 1'b1;
      #2;
      compareVal("rst0.result", bus_if.result, 4'h0);
      compareVal("rst0.zero",   {3'b0, bus_if.zero},  4'h0);
      compareVal("rst0.carry",  {3'b0, bus_if.carry}, 4'h0);
      @(posedge clk);
      #1;
      clr = 1'b1;

      // Arithmetic with carry/borrow
      applyStimulus("ldi1",  4'd0,  4'd1,  4'd9,  1'b0, 4'd9,  1'b0, 1'b0, 4'd9);
      applyStimulus("ldi2",  4'd0,  4'd2,  4'd8,  1'b0, 4'd8,  1'b0, 1'b0, 4'd8);
      applyStimulus("add",   4'd2,  4'd1,  4'd2,  1'b0, 4'd1,  1'b1, 1'b0, 4'd1);
      applyStimulus("ldi3",  4'd0,  4'd3,  4'd5,  1'b0, 4'd5,  1'b1, 1'b0, 4'd5);
      applyStimulus("ldi4",  4'd0,  4'd4,  4'd7,  1'b0, 4'd7,  1'b1, 1'b0, 4'd7);
      applyStimulus("subb",  4'd3,  4'd3,  4'd4,  1'b0, 4'd14, 1'b1, 1'b0, 4'd14);
      applyStimulus("ldi4b", 4'd0,  4'd4,  4'd14, 1'b0, 4'd14, 1'b1, 1'b0, 4'd14);
      applyStimulus("subz",  4'd3,  4'd3,  4'd4,  1'b0, 4'd0,  1'b0, 1'b1, 4'd0);

      // Shifts, rotates and wrap
      applyStimulus("ldi5",  4'd0,  4'd5,  4'd9,  1'b0, 4'd9,  1'b0, 1'b0, 4'd9);
      applyStimulus("rol",   4'd12, 4'd5,  4'd0,  1'b0, 4'd3,  1'b1, 1'b0, 4'd3);
      applyStimulus("shr",   4'd11, 4'd5,  4'd0,  1'b0, 4'd1,  1'b1, 1'b0, 4'd1);
      applyStimulus("ldi6",  4'd0,  4'd6,  4'd15, 1'b0, 4'd15, 1'b1, 1'b0, 4'd15);
      applyStimulus("incw",  4'd8,  4'd6,  4'd0,  1'b0, 4'd0,  1'b1, 1'b1, 4'd0);

      // NOP holds everything; same-address XOR clears
      applyStimulus("ldi7",  4'd0,  4'd7,  4'd10, 1'b0, 4'd10, 1'b1, 1'b0, 4'd10);
      applyStimulus("nop",   4'd15, 4'd7,  4'd3,  1'b0, 4'd10, 1'b1, 1'b0, 4'd10);
      applyStimulus("xor",   4'd6,  4'd7,  4'd7,  1'b0, 4'd0,  1'b1, 1'b1, 4'd0);

      applyStimulus("decw",  4'd9,  4'd6,  4'd0,  1'b0, 4'd15, 1'b1, 1'b0, 4'd15);
      applyStimulus("shl",   4'd10, 4'd6,  4'd0,  1'b0, 4'd14, 1'b1, 1'b0, 4'd14);
      applyStimulus("ror",   4'd13, 4'd6,  4'd0,  1'b0, 4'd7,  1'b0, 1'b0, 4'd7);
      applyStimulus("ldi8",  4'd0,  4'd8,  4'd12, 1'b0, 4'd12, 1'b0, 1'b0, 4'd12);
      applyStimulus("and",   4'd4,  4'd8,  4'd5,  1'b0, 4'd0,  1'b0, 1'b1, 4'd0);
      applyStimulus("or",    4'd5,  4'd8,  4'd6,  1'b0, 4'd7,  1'b0, 1'b0, 4'd7);
      applyStimulus("not",   4'd7,  4'd9,  4'd8,  1'b0, 4'd8,  1'b0, 1'b0, 4'd8);
      applyStimulus("mov",   4'd1,  4'd10, 4'd9,  1'b0, 4'd8,  1'b0, 1'b0, 4'd8);
      applyStimulus("addnc", 4'd2,  4'd9,  4'd6,  1'b0, 4'd15, 1'b0, 1'b0, 4'd15);
      applyStimulus("clr",   4'd14, 4'd10, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1, 4'd0);
      applyStimulus("shl9",  4'd10, 4'd9,  4'd0,  1'b0, 4'd14, 1'b1, 1'b0, 4'd14);

      // Read mode: RF frozen, result mirrors RF[addr_a], carry held at 1
      for (int i = 0; i < 16; i++) rf_model[i] = 4'd0;
      rf_model[1] = 4'd1;  rf_model[2] = 4'd8;  rf_model[4] = 4'd14;
      rf_model[5] = 4'd1;  rf_model[6] = 4'd7;  rf_model[8] = 4'd7;
      rf_model[9] = 4'd14;
      for (int i = 0; i < 16; i++) begin
         logic [3:0] a;
         a = 4'((i * 7) % 16);
         applyStimulus($sformatf("rd%0d", i), 4'(i), a, 4'(15 - i), 1'b1,
                       rf_model[a], 1'b1, (rf_model[a] == 4'd0), rf_model[a]);
      end

      // Asynchronous reset between edges discards the pending write
      bus_if.instr  = 4'd0;
      bus_if.addr_a = 4'd1;
      bus_if.addr_b = 4'd5;
      bus_if.wr_re  = 1'b0;
      #2;
      clr = 1'b0;
      #1;
      compareVal("arst.data_a", bus_if.data_a, 4'h0);
      compareVal("arst.data_b", bus_if.data_b, 4'h0);
      compareVal("arst.result", bus_if.result, 4'h0);
      compareVal("arst.carry",  {3'b0, bus_if.carry}, 4'h0);
      compareVal("arst.zero",   {3'b0, bus_if.zero},  4'h0);
      @(posedge clk);
      #1;
      compareVal("arst.hold",   bus_if.data_a, 4'h0);
      bus_if.wr_re = 1'b1;
      clr = 1'b1;
      applyStimulus("post", 4'd0, 4'd1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 4'd0);
      compareVal("post.data_b", bus_if.data_b, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
